// File: rtl/raster_stamp_csr_buf.sv
// raster_stamp_csr_buf: stamp FIFO between the rasterizer core and the raster
// CSR unit. A warp request pulls one stamp per active lane, each stamp is
// converted to CSR layout as it lands in its lane slot, and the whole lane set
// is returned as a single response.
//
// Optional feature: define RASTER_GRAD_EN to populate grad_x/grad_y with
// bcoord_x[1]-bcoord_x[0] and bcoord_x[2]-bcoord_x[0]. Without the macro both
// fields read as zero and no subtractors exist.
//
// Handshake rule (all three channels): a transfer happens on a rising clk edge
// where valid && ready are both high; valid never depends on ready, and the
// payload is held stable while valid is high and ready is low.
//
// Stamp layout (LSB first): pos_x[15:0], pos_y[15:0], mask[3:0], pid[15:0],
// bcoord_x[4][32], bcoord_y[4][32], bcoord_z[4][32]  -> 436 bits.
// CSR layout (LSB first): pos_y_x[31:0], pid_mask[31:0], bcoord_x[4][32],
// bcoord_y[4][32], bcoord_z[4][32], grad_x[31:0], grad_y[31:0] -> 512 bits.
// Lane 0 occupies the least significant CSR_W bits of rsp_csrs.
//
// dbg_state exposes the FSM: 0 = IDLE, 1 = FILL, 2 = RSP.

module raster_stamp_csr_buf #(
  parameter int NUM_LANES  = 4,
  parameter int FIFO_DEPTH = 8,
  localparam int STAMP_W   = 436,
  localparam int CSR_W     = 512,
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         stamp_valid,
  input  logic [STAMP_W-1:0]           stamp_data,
  output logic                         stamp_ready,
  input  logic                         raster_done,
  input  logic                         req_valid,
  input  logic [NUM_LANES-1:0]         req_tmask,
  output logic                         req_ready,
  output logic                         rsp_valid,
  output logic [NUM_LANES*CSR_W-1:0]   rsp_csrs,
  output logic [NUM_LANES-1:0]         rsp_tmask,
  output logic                         rsp_done,
  input  logic                         rsp_ready,
  output logic [CNT_W-1:0]             fifo_count,
  output logic [1:0]                   dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  typedef struct packed {
    logic [3:0][31:0] bcoord_z;
    logic [3:0][31:0] bcoord_y;
    logic [3:0][31:0] bcoord_x;
    logic [15:0]      pid;
    logic [3:0]       mask;
    logic [15:0]      pos_y;
    logic [15:0]      pos_x;
  } stamp_t;

  typedef struct packed {
    logic [31:0]      grad_y;
    logic [31:0]      grad_x;
    logic [3:0][31:0] bcoord_z;
    logic [3:0][31:0] bcoord_y;
    logic [3:0][31:0] bcoord_x;
    logic [31:0]      pid_mask;
    logic [31:0]      pos_y_x;
  } csrs_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_next_state;

  stamp_t                    r_mem [FIFO_DEPTH];
  logic [AW-1:0]             r_wptr;
  logic [AW-1:0]             r_rptr;
  logic [CNT_W-1:0]          r_count;

  logic [NUM_LANES-1:0]      r_tmask;
  logic [NUM_LANES-1:0]      r_rsp_tmask;
  logic [LW-1:0]             r_lane;
  csrs_t [NUM_LANES-1:0]     r_slots;
  logic                      r_rsp_done;

  logic                      w_push;
  logic                      w_pop;
  logic                      w_fifo_empty;
  logic                      w_lane_bit;
  logic                      w_advance;
  logic                      w_last_lane;
  logic                      w_req_fire;
  logic [NUM_LANES-1:0]      w_lane_onehot;
  logic [NUM_LANES-1:0]      w_tmask_next;
  stamp_t                    w_head;
  csrs_t                     w_conv;
  logic [31:0]               w_grad_x;
  logic [31:0]               w_grad_y;

  // ---------------------------------------------------------------------------
  // FIFO control. Readiness comes only from the registered count, so a pop in
  // the same cycle never frees room for a push into a full FIFO.
  // ---------------------------------------------------------------------------
  assign w_fifo_empty  = (r_count == '0);
  assign stamp_ready   = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push        = stamp_valid && stamp_ready;
  assign w_head        = r_mem[r_rptr];
  assign fifo_count    = r_count;

  // Lane evaluation: a lane holding an active bit waits for a stamp unless
  // the rasterizer has declared it will produce no more.
  assign w_lane_bit    = r_tmask[r_lane];
  assign w_pop         = (r_state == ST_FILL) && w_lane_bit && !w_fifo_empty;
  assign w_advance     = (r_state == ST_FILL) &&
                         (!w_lane_bit || !w_fifo_empty || raster_done);
  assign w_last_lane   = (r_lane == LW'(NUM_LANES - 1));
  assign w_req_fire    = req_valid && req_ready;
  assign w_lane_onehot = NUM_LANES'(1) << r_lane;
  assign w_tmask_next  = r_rsp_tmask | (w_pop ? w_lane_onehot : '0);

  // Stamp storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= stamp_t'(stamp_data);
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Stamp-to-CSR conversion of the FIFO head, registered into the lane slot.
  // ---------------------------------------------------------------------------
`ifdef RASTER_GRAD_EN
  assign w_grad_x = w_head.bcoord_x[1] - w_head.bcoord_x[0];
  assign w_grad_y = w_head.bcoord_x[2] - w_head.bcoord_x[0];
`else
  assign w_grad_x = '0;
  assign w_grad_y = '0;
`endif

  // Repack the head stamp into CSR field order.
  always_comb begin
    w_conv          = '0;
    w_conv.pos_y_x  = {w_head.pos_y, w_head.pos_x};
    w_conv.pid_mask = {12'b0, w_head.pid, w_head.mask};
    w_conv.bcoord_x = w_head.bcoord_x;
    w_conv.bcoord_y = w_head.bcoord_y;
    w_conv.bcoord_z = w_head.bcoord_z;
    w_conv.grad_x   = w_grad_x;
    w_conv.grad_y   = w_grad_y;
  end

  // ---------------------------------------------------------------------------
  // Request FSM.
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: one lane per FILL cycle, leave after the last lane.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_req_fire)               w_next_state = ST_FILL;
      ST_FILL: if (w_advance && w_last_lane) w_next_state = ST_RSP;
      ST_RSP:  if (rsp_ready)                w_next_state = ST_IDLE;
      default:                               w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs; req_ready is forced low for as long as reset is held.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    dbg_state = r_state;
    case (r_state)
      ST_IDLE: req_ready = reset_n;
      ST_RSP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Per-request datapath: latch the mask, fill slots lane by lane, settle the
  // done flag when the last lane is passed. Held untouched during RSP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmask     <= '0;
      r_rsp_tmask <= '0;
      r_lane      <= '0;
      r_slots     <= '0;
      r_rsp_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_fire) begin
            r_tmask     <= req_tmask;
            r_rsp_tmask <= '0;
            r_slots     <= '0;
            r_rsp_done  <= 1'b0;
            r_lane      <= '0;
          end
        end
        ST_FILL: begin
          if (w_pop) begin
            r_slots[r_lane] <= w_conv;
          end
          if (w_advance) begin
            r_rsp_tmask <= w_tmask_next;
            if (w_last_lane) begin
              r_rsp_done <= (w_tmask_next == '0) && raster_done;
            end else begin
              r_lane <= r_lane + LW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_csrs  = r_slots;
  assign rsp_tmask = r_rsp_tmask;
  assign rsp_done  = r_rsp_done;

endmodule

// File: tb/tb_raster_stamp_csr_buf.sv
// Testbench for raster_stamp_csr_buf: table-driven request patterns, directed
// corner sequences (basic fill, full FIFO, stall/drain, gradients, async
// reset) and randomized traffic checked against a lane-by-lane queue model.

module tb_raster_stamp_csr_buf;

  localparam int NL      = 4;
  localparam int FD      = 8;
  localparam int STAMP_W = 436;
  localparam int CSR_W   = 512;
  localparam int CNT_W   = $clog2(FD) + 1;

  typedef struct packed {
    logic [3:0][31:0] bcoord_z;
    logic [3:0][31:0] bcoord_y;
    logic [3:0][31:0] bcoord_x;
    logic [15:0]      pid;
    logic [3:0]       mask;
    logic [15:0]      pos_y;
    logic [15:0]      pos_x;
  } stamp_t;

  typedef struct packed {
    logic [31:0]      grad_y;
    logic [31:0]      grad_x;
    logic [3:0][31:0] bcoord_z;
    logic [3:0][31:0] bcoord_y;
    logic [3:0][31:0] bcoord_x;
    logic [31:0]      pid_mask;
    logic [31:0]      pos_y_x;
  } csrs_t;

  typedef struct {
    int         n_push;
    logic [3:0] tmask;
    logic [3:0] exp_tmask;
    int         exp_count;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk;
  logic                    reset_n;
  logic                    stamp_valid;
  logic [STAMP_W-1:0]      stamp_data;
  logic                    stamp_ready;
  logic                    raster_done;
  logic                    req_valid;
  logic [NL-1:0]           req_tmask;
  logic                    req_ready;
  logic                    rsp_valid;
  logic [NL*CSR_W-1:0]     rsp_csrs;
  logic [NL-1:0]           rsp_tmask;
  logic                    rsp_done;
  logic                    rsp_ready;
  logic [CNT_W-1:0]        fifo_count;
  logic [1:0]              dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  raster_stamp_csr_buf #(.NUM_LANES(NL), .FIFO_DEPTH(FD)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stamp_valid (stamp_valid),
    .stamp_data  (stamp_data),
    .stamp_ready (stamp_ready),
    .raster_done (raster_done),
    .req_valid   (req_valid),
    .req_tmask   (req_tmask),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_csrs    (rsp_csrs),
    .rsp_tmask   (rsp_tmask),
    .rsp_done    (rsp_done),
    .rsp_ready   (rsp_ready),
    .fifo_count  (fifo_count),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int                      n_checks = 0;
  int                      n_errors = 0;
  logic [STAMP_W-1:0]      exp_q[$];
  csrs_t                   exp_l [NL];
  logic [NL-1:0]           exp_tm;
  logic                    exp_done;
  logic [NL*CSR_W-1:0]     got_csrs;
  logic [NL-1:0]           got_tm;
  logic                    got_done;
  int                      got_lat;
  vec_t                    tbl [7];

  task automatic chk(input string name, input logic [CSR_W-1:0] act,
                     input logic [CSR_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic csrs_t conv(input stamp_t s);
    csrs_t c;
    c          = '0;
    c.pos_y_x  = {s.pos_y, s.pos_x};
    c.pid_mask = {12'h000, s.pid, s.mask};
    c.bcoord_x = s.bcoord_x;
    c.bcoord_y = s.bcoord_y;
    c.bcoord_z = s.bcoord_z;
`ifdef RASTER_GRAD_EN
    c.grad_x   = s.bcoord_x[1] - s.bcoord_x[0];
    c.grad_y   = s.bcoord_x[2] - s.bcoord_x[0];
`endif
    return c;
  endfunction

  // Expected response for a request resolved with the given raster_done:
  // each active lane takes the oldest queued stamp, or stays empty once drained.
  task automatic model_req(input logic [NL-1:0] tm, input logic done);
    exp_tm = '0;
    for (int i = 0; i < NL; i++) begin
      exp_l[i] = '0;
      if (tm[i] && exp_q.size() > 0) begin
        exp_l[i]  = conv(stamp_t'(exp_q.pop_front()));
        exp_tm[i] = 1'b1;
      end
    end
    exp_done = (exp_tm == '0) && done;
  endtask

  function automatic stamp_t rand_stamp();
    stamp_t s;
    s.pos_x = 16'($urandom);
    s.pos_y = 16'($urandom);
    s.mask  = 4'($urandom);
    s.pid   = 16'($urandom);
    for (int j = 0; j < 4; j++) begin
      s.bcoord_x[j] = $urandom;
      s.bcoord_y[j] = $urandom;
      s.bcoord_z[j] = $urandom;
    end
    return s;
  endfunction

  function automatic stamp_t mk_stamp(input int k);
    stamp_t s;
    s.pos_x = 16'(k * 3 + 1);
    s.pos_y = 16'(k + 100);
    s.mask  = 4'(k);
    s.pid   = 16'(k * 7);
    for (int j = 0; j < 4; j++) begin
      s.bcoord_x[j] = 32'(k * 16 + j);
      s.bcoord_y[j] = 32'(k * 16 + j + 4);
      s.bcoord_z[j] = 32'(k * 16 + j + 8);
    end
    return s;
  endfunction

  // ---------------- drivers (enter and leave 1 time unit after posedge) ----
  task automatic push_stamp(input stamp_t s);
    int n;
    n           = 0;
    stamp_valid = 1'b1;
    stamp_data  = s;
    while (!stamp_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("push_ready_seen", stamp_ready, 1'b1);
    @(posedge clk); #1;
    stamp_valid = 1'b0;
    exp_q.push_back(s);
  endtask

  task automatic fire_req(input logic [NL-1:0] tm);
    int n;
    n         = 0;
    req_valid = 1'b1;
    req_tmask = tm;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_ready_seen", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Wait for the response, hold it for 'hold' cycles checking stability,
  // then accept it.
  task automatic wait_rsp(input int hold);
    got_lat = 0;
    while (!rsp_valid && got_lat < 300) begin
      @(posedge clk); #1;
      got_lat++;
    end
    chk("rsp_valid_seen", rsp_valid, 1'b1);
    got_csrs = rsp_csrs;
    got_tm   = rsp_tmask;
    got_done = rsp_done;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("rsp_hold_valid", rsp_valid, 1'b1);
      chk("rsp_hold_csrs", rsp_csrs, got_csrs);
      chk("rsp_hold_tmask", rsp_tmask, got_tm);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", rsp_valid, 1'b0);
  endtask

  task automatic check_rsp();
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("lane%0d_csrs", i), got_csrs[i*CSR_W +: CSR_W], exp_l[i]);
    end
    chk("rsp_tmask", got_tm, exp_tm);
    chk("rsp_done", got_done, exp_done);
    chk("fifo_count", fifo_count, CNT_W'(exp_q.size()));
  endtask

  // Complete request with no stall expected. rsp_valid is first seen after
  // NL edges past the fire edge, i.e. it is high in the (NL+1)th cycle.
  task automatic run_req(input logic [NL-1:0] tm, input int hold);
    model_req(tm, raster_done);
    fire_req(tm);
    wait_rsp(hold);
    chk("latency", got_lat, NL);
    check_rsp();
  endtask

  task automatic drain_all();
    int k;
    while (exp_q.size() > 0) begin
      k = (exp_q.size() > NL) ? NL : exp_q.size();
      run_req(NL'((1 << k) - 1), 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    stamp_t     s;
    csrs_t      c;
    int         n;
    int         k;
    int         avail;
    logic [3:0] tm;

    reset_n     = 1'b0;
    stamp_valid = 1'b0;
    stamp_data  = '0;
    raster_done = 1'b0;
    req_valid   = 1'b0;
    req_tmask   = '0;
    rsp_ready   = 1'b0;

    // Reset state.
    #2;
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_tmask", rsp_tmask, 0);
    chk("rst_rsp_done", rsp_done, 0);
    chk("rst_rsp_csrs", rsp_csrs[CSR_W-1:0], 0);
    chk("rst_req_ready", req_ready, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_req_ready", req_ready, 1'b1);

    // Basic fill.
    for (int i = 0; i < 4; i++) begin
      s       = rand_stamp();
      s.pos_x = 16'(i + 1);
      s.pos_y = 16'h0007;
      s.pid   = 16'h0055;
      s.mask  = 4'hF;
      push_stamp(s);
    end
    run_req(4'b1111, 0);
    for (int i = 0; i < NL; i++) begin
      c = csrs_t'(got_csrs[i*CSR_W +: CSR_W]);
      chk("basic_pos_y_x", c.pos_y_x, 32'h0007_0000 + 32'(i + 1));
      chk("basic_pid_mask", c.pid_mask, 32'h0000_055F);
    end
    chk("basic_tmask", got_tm, 4'b1111);
    chk("basic_done", got_done, 1'b0);
    chk("basic_count", fifo_count, 0);

    // Table-driven request patterns (raster_done low, no stalls).
    tbl[0] = '{2, 4'b0101, 4'b0101, 0};
    tbl[1] = '{3, 4'b0010, 4'b0010, 2};
    tbl[2] = '{0, 4'b1000, 4'b1000, 1};
    tbl[3] = '{0, 4'b0001, 4'b0001, 0};
    tbl[4] = '{1, 4'b0000, 4'b0000, 1};
    tbl[5] = '{3, 4'b1110, 4'b1110, 1};
    tbl[6] = '{0, 4'b0100, 4'b0100, 0};
    k = 0;
    for (int v = 0; v < 7; v++) begin
      for (int p = 0; p < tbl[v].n_push; p++) begin
        push_stamp(mk_stamp(k));
        k++;
      end
      run_req(tbl[v].tmask, v % 3);
      chk("tbl_tmask", got_tm, tbl[v].exp_tmask);
      chk("tbl_count", fifo_count, tbl[v].exp_count);
      chk("tbl_done", got_done, 1'b0);
    end

    // Random traffic, raster_done low: only ask for lanes that can be served.
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(0, (FD - exp_q.size() < 4) ? FD - exp_q.size() : 4);
      for (int p = 0; p < n; p++) push_stamp(rand_stamp());
      tm    = 4'($urandom_range(0, 15));
      avail = exp_q.size();
      for (int i = 0; i < NL; i++) begin
        if (tm[i]) begin
          if (avail > 0) avail--;
          else tm[i] = 1'b0;
        end
      end
      run_req(tm, $urandom_range(0, 3));
    end
    drain_all();

    // Full FIFO and response backpressure.
    n           = 0;
    stamp_valid = 1'b1;
    while (stamp_ready && n < 20) begin
      s          = rand_stamp();
      stamp_data = s;
      @(posedge clk); #1;
      exp_q.push_back(s);
      n++;
    end
    stamp_valid = 1'b0;
    chk("full_pushes", n, FD);
    chk("full_count", fifo_count, FD);
    chk("full_ready_low", stamp_ready, 1'b0);
    model_req(4'b0001, raster_done);
    fire_req(4'b0001);
    chk("full_ready_before_pop", stamp_ready, 1'b0);
    @(posedge clk); #1;
    chk("full_ready_after_pop", stamp_ready, 1'b1);
    wait_rsp(5);
    chk("full_latency", got_lat, NL - 1);
    check_rsp();

    // Stall on an empty FIFO, then release with raster_done.
    drain_all();
    push_stamp(rand_stamp());
    model_req(4'b0011, 1'b1);
    fire_req(4'b0011);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_rsp_valid", rsp_valid, 1'b0);
      chk("stall_req_ready", req_ready, 1'b0);
    end
    raster_done = 1'b1;
    wait_rsp(0);
    check_rsp();
    chk("stall_tmask", got_tm, 4'b0001);
    chk("stall_done", got_done, 1'b0);
    run_req(4'b1111, 0);
    chk("drained_tmask", got_tm, 4'b0000);
    chk("drained_done", got_done, 1'b1);
    run_req(4'b0000, 1);
    chk("zero_mask_done", got_done, 1'b1);

    // Random traffic with the rasterizer drained: any mask is legal.
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(0, (FD - exp_q.size() < 3) ? FD - exp_q.size() : 3);
      for (int p = 0; p < n; p++) push_stamp(rand_stamp());
      run_req(4'($urandom_range(0, 15)), $urandom_range(0, 2));
    end
    drain_all();

    // Gradient fields.
    s             = rand_stamp();
    s.bcoord_x[0] = 32'h10;
    s.bcoord_x[1] = 32'h30;
    s.bcoord_x[2] = 32'h05;
    s.bcoord_x[3] = 32'h00;
    push_stamp(s);
    run_req(4'b0001, 0);
    c = csrs_t'(got_csrs[CSR_W-1:0]);
`ifdef RASTER_GRAD_EN
    chk("grad_x", c.grad_x, 32'h0000_0020);
    chk("grad_y", c.grad_y, 32'hFFFF_FFF5);
`else
    chk("grad_x", c.grad_x, 32'h0);
    chk("grad_y", c.grad_y, 32'h0);
`endif

    // Asynchronous reset while lane 2 is being evaluated.
    for (int i = 0; i < 4; i++) push_stamp(rand_stamp());
    fire_req(4'b0001);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_count", fifo_count, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_fifo_count", fifo_count, 0);
    chk("arst_req_ready", req_ready, 1'b0);
    chk("arst_stamp_ready", stamp_ready, 1'b1);
    exp_q.delete();
    raster_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_req_ready", req_ready, 1'b1);
    chk("post_reset_tmask", rsp_tmask, 0);
    push_stamp(rand_stamp());
    run_req(4'b0001, 0);
    chk("post_reset_served", got_tm, 4'b0001);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "timeout");
  end

endmodule
